// File: rtl/random_tile_spawner.sv
// Post-move tile spawner for the 2048 board: from a pseudo-random start cell it scans
// with wrap-around for the first empty cell and places a "2" or "4" tile there.
module random_tile_spawner #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter logic [3:0]  TILE_LOW  = 4'd1,
   parameter logic [3:0]  TILE_HIGH = 4'd2,
   parameter int          HIGH_BITS = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] board_in,
   input  logic        force_en,
   input  logic [3:0]  force_idx,
   input  logic        force_high,
   output logic [63:0] board_out,
   output logic        busy,
   output logic        done,
   output logic        full,
   output logic [3:0]  rand_out
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t      state, state_nxt;
   logic [15:0] lfsr;
   logic [63:0] board_reg, board_reg_nxt;
   logic [63:0] board_out_nxt;
   logic [3:0]  idx, idx_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        high, high_nxt;
   logic        busy_nxt, done_nxt, full_nxt;
   logic [3:0]  cur_cell;
   logic        high_draw;

   function automatic logic [3:0] get_cell(input logic [63:0] b, input logic [3:0] k);
      return b[{k, 2'b00} +: 4];
   endfunction

   function automatic logic [63:0] set_cell(input logic [63:0] b, input logic [3:0] k,
                                            input logic [3:0] v);
      logic [63:0] r;
      r = b;
      r[{k, 2'b00} +: 4] = v;
      return r;
   endfunction

   assign rand_out  = lfsr[3:0];
   assign cur_cell  = get_cell(board_reg, idx);
   assign high_draw = &lfsr[HIGH_BITS+3:4];

   // Free-running x^16+x^14+x^13+x^11+1 Fibonacci LFSR, independent of the FSM.
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr <= SEED_EFF;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         board_out <= 64'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         full      <= 1'b0;
      end else begin
         state     <= state_nxt;
         board_out <= board_out_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         full      <= full_nxt;
      end
   end

   // Scan context is only meaningful inside SCAN, so it carries no reset.
   always_ff @(posedge clock) begin
      board_reg <= board_reg_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      high      <= high_nxt;
   end

   always_comb begin
      state_nxt     = state;
      board_reg_nxt = board_reg;
      idx_nxt       = idx;
      cnt_nxt       = cnt;
      high_nxt      = high;
      board_out_nxt = board_out;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      full_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               board_reg_nxt = board_in;
               idx_nxt       = force_en ? force_idx : lfsr[3:0];
               high_nxt      = force_en ? force_high : high_draw;
               cnt_nxt       = 4'd0;
               busy_nxt      = 1'b1;
               state_nxt     = SCAN;
            end
         end
         SCAN: begin
            if (cur_cell == 4'd0) begin
               board_out_nxt = set_cell(board_reg, idx, high ? TILE_HIGH : TILE_LOW);
               done_nxt      = 1'b1;
               busy_nxt      = 1'b0;
               state_nxt     = IDLE;
            end else if (cnt == 4'd15) begin
               board_out_nxt = board_reg;
               done_nxt      = 1'b1;
               full_nxt      = 1'b1;
               busy_nxt      = 1'b0;
               state_nxt     = IDLE;
            end else begin
               // 4-bit index wraps 15 -> 0 naturally.
               idx_nxt = idx + 4'd1;
               cnt_nxt = cnt + 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule
